half_adder_df: RTL and testbench
================================

Name: half_adder_df

Overview:
- Dataflow half adder: each lane computes sum = A xor B and carry = A and B.
- Outputs are provided in two forms: combinational (same-cycle) and registered (one clock later).
- A saturating counter records how many enabled cycles produced at least one carry.
- Sits as a leaf arithmetic primitive for adder chains and for bring-up/teaching benches.

Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes (min 1).
- CNT_W, 16, width of the carry-event counter (min 1).

Ports:
- clk  input  1  single clock; all registers update on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  registered-path enable.
- A  input  WIDTH  operand A, lane i = A[i].
- B  input  WIDTH  operand B, lane i = B[i].
- Cout  output  WIDTH  combinational carry, lane i = A[i] & B[i].
- S  output  WIDTH  combinational sum, lane i = A[i] ^ B[i].
- Cout_q  output  WIDTH  registered Cout.
- S_q  output  WIDTH  registered S.
- carry_cnt  output  CNT_W  saturating count of carry events.

Behaviour:
- Combinational path:
  - S and Cout are pure continuous assignments with no clock dependency.
  - They follow A/B within the same delta, in reset too.
  - Truth table per lane (A,B -> S,Cout): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Lanes are independent; there is no carry propagation between lanes.
- Arithmetic identity per lane: {Cout[i],S[i]} = A[i] + B[i] (2-bit result).
- Registered path:
  - On a rising clk edge with en=1: S_q <= S and Cout_q <= Cout. Latency is exactly 1 cycle.
  - With en=0: S_q and Cout_q hold their values.
- Carry counter:
  - On a rising edge with en=1 and |Cout = 1: carry_cnt increments by 1.
  - It saturates at all-ones and never wraps.
  - With en=0, or with no lane carrying, it holds.
- Reset:
  - rst_n=0 immediately (asynchronously) clears S_q, Cout_q and carry_cnt to 0.
  - Combinational S/Cout are unaffected by reset.
  - Release of rst_n is synchronous to the next clk edge. The first capture occurs on the first rising edge with rst_n=1 and en=1.
- Reset mid-operation: any pending capture is discarded and the registered outputs read 0 until the next enabled edge.
- X/Z inputs: no special handling; propagate per standard Verilog operators.

Decomposition:
- Package half_adder_pkg: default WIDTH and CNT_W localparams, and a CNT_MAX constant (all-ones of CNT_W) used by the saturation check.
- Sub-module half_adder_bit: one lane, inputs a and b, outputs s and c, pure dataflow. Instantiated WIDTH times in a generate loop.
- Registers and counter live in the top module.

Test Plan:
- WIDTH=1, no clock needed: apply A,B = 00, 01, 10, 11 at 5-unit spacing. Require S,Cout = 0,0 / 1,0 / 1,0 / 0,1 at each step.
- Registered latency:
  - Apply en=1, A=1, B=1 before edge k.
  - Require Cout_q=0, S_q=0 before edge k, then Cout_q=1, S_q=0 after edge k.
  - carry_cnt goes 0 -> 1.
- Enable hold:
  - Capture A=0, B=1 (S_q=1), then set en=0 and A=1, B=1 for 3 edges.
  - Require S_q=1, Cout_q=0 and carry_cnt unchanged; combinational Cout=1 meanwhile.
- Async reset mid-run:
  - After carry_cnt=5, drive rst_n=0 between edges.
  - Require S_q, Cout_q and carry_cnt = 0 immediately, without waiting for clk.
  - Combinational S/Cout still track A/B.
- Saturation: CNT_W=2, en=1, A=B=1 for 6 edges. Require carry_cnt sequence 1, 2, 3, 3, 3, 3.
- Multi-lane: WIDTH=4, A=4'b1100, B=4'b1010. Require S=4'b0110 and Cout=4'b1000; one edge later S_q/Cout_q equal the same values and carry_cnt increments by 1.

Source files
------------

// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared defaults and counter saturation limit for the half adder slice.
package half_adder_pkg;
    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;
    // Shifting by 64 wraps to zero, so the subtraction still yields all-ones.
    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = DEF_CNT_W'(cnt_max(DEF_CNT_W));
endpackage

// File: rtl/half_adder_bit.sv
// half_adder_bit: single-lane dataflow half adder.
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/half_adder_df.sv
// half_adder_df: multi-lane half adder with combinational and registered outputs
// plus a saturating count of enabled carry cycles.
module half_adder_df
    import half_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Cout,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Cout_q,
    output logic [WIDTH-1:0] S_q,
    output logic [CNT_W-1:0] carry_cnt
);
    localparam logic [CNT_W-1:0] W_CNT_MAX = CNT_W'(cnt_max(CNT_W));
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (.a(A[i]), .b(B[i]), .s(S[i]), .c(Cout[i]));
    end
    assign w_inc = en && (|Cout) && (r_cnt != W_CNT_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s   <= '0;
            r_c   <= '0;
            r_cnt <= '0;
        end else begin
            if (en) begin
                r_s <= S;
                r_c <= Cout;
            end
            if (w_inc) r_cnt <= r_cnt + 1'b1;
        end
    end
    assign S_q       = r_s;
    assign Cout_q    = r_c;
    assign carry_cnt = r_cnt;
endmodule

// File: tb/tb_half_adder_df.sv
// tb_half_adder_df: directed checks of the half adder across default, 2-bit counter and 4-lane builds.
module tb_half_adder_df;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic        c1, s1, cq1, sq1;
    logic [15:0] cnt1;
    logic        en2 = 1'b0, a2 = 1'b0, b2 = 1'b0;
    logic        c2, s2, cq2, sq2;
    logic [1:0]  cnt2;
    logic        en3 = 1'b0;
    logic [3:0]  a3 = '0, b3 = '0, c3, s3, cq3, sq3;
    logic [15:0] cnt3;
    int          n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    half_adder_df u_dut1 (.clk(clk), .rst_n(rst_n), .en(en1), .A(a1), .B(b1),
        .Cout(c1), .S(s1), .Cout_q(cq1), .S_q(sq1), .carry_cnt(cnt1));
    half_adder_df #(.WIDTH(1), .CNT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .en(en2), .A(a2), .B(b2),
        .Cout(c2), .S(s2), .Cout_q(cq2), .S_q(sq2), .carry_cnt(cnt2));
    half_adder_df #(.WIDTH(4), .CNT_W(16)) u_dut3 (.clk(clk), .rst_n(rst_n), .en(en3), .A(a3), .B(b3),
        .Cout(c3), .S(s3), .Cout_q(cq3), .S_q(sq3), .carry_cnt(cnt3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] vec [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
        int         sat [6] = '{1, 2, 3, 3, 3, 3};
        #1;
        check("rst_sq", sq1, 0);
        check("rst_cq", cq1, 0);
        check("rst_cnt", cnt1, 0);
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = vec[i];
            #5;
            check($sformatf("comb_%0d_S", i), s1, exp[i][1]);
            check($sformatf("comb_%0d_C", i), c1, exp[i][0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        #1;
        check("lat_pre_cq", cq1, 0);
        check("lat_pre_sq", sq1, 0);
        check("lat_pre_cnt", cnt1, 0);
        tick();
        check("lat_cq", cq1, 1);
        check("lat_sq", sq1, 0);
        check("lat_cnt", cnt1, 1);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1;
        tick();
        check("cap_sq", sq1, 1);
        check("cap_cnt", cnt1, 1);
        @(negedge clk);
        en1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_%0d_sq", i), sq1, 1);
            check($sformatf("hold_%0d_cq", i), cq1, 0);
            check($sformatf("hold_%0d_cnt", i), cnt1, 1);
            check($sformatf("hold_%0d_C", i), c1, 1);
        end
        @(negedge clk);
        en1 = 1'b1;
        repeat (4) tick();
        check("pre_rst_cnt", cnt1, 5);
        check("pre_rst_cq", cq1, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sq", sq1, 0);
        check("arst_cq", cq1, 0);
        check("arst_cnt", cnt1, 0);
        a1 = 1'b1; b1 = 1'b0;
        #1;
        check("arst_S", s1, 1);
        check("arst_C", c1, 0);
        tick();
        check("arst_hold_sq", sq1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_sq", sq1, 1);
        check("post_rst_cnt", cnt1, 0);
        @(negedge clk);
        en1 = 1'b0;
        en2 = 1'b1; a2 = 1'b1; b2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("sat_%0d", i), cnt2, sat[i]);
        end
        @(negedge clk);
        en2 = 1'b0;
        a3 = 4'b1100; b3 = 4'b1010;
        #1;
        check("ml_S", s3, 4'b0110);
        check("ml_C", c3, 4'b1000);
        check("ml_pre_cnt", cnt3, 0);
        en3 = 1'b1;
        tick();
        check("ml_sq", sq3, 4'b0110);
        check("ml_cq", cq3, 4'b1000);
        check("ml_cnt", cnt3, 1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
